mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface, located in the MEM pipeline stage.
- Converts MEM-stage operations (load, store, push, pop, 32-bit call/return frames) into single-word chip-select/read/write strobes toward the 2K x 16 data memory.
- Owns the stack pointer.
- Splits 32-bit PC transfers into two sequential 16-bit accesses and stalls the pipeline while doing so.

Parameters:
- ADDR_W, 32, width of effective address and memory address bus
- DATA_W, 16, memory word width
- STACK_TOP, 2047, SP reset value; stack grows downward from here
- STACK_LIMIT, 1024, lowest legal stack word; used only by the guard feature

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  MEM-stage operation present
- op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL (push32), 6 RET (pop32)
- ea  in  ADDR_W  effective address for LOAD/STORE
- wdata  in  DATA_W  store/push data
- pc_in  in  32  return PC for CALL
- stall  out  1  hold upstream stages; op inputs must stay stable while high
- rdata  out  32  load/pop result, zero-extended for 16-bit ops
- rdata_valid  out  1  one-cycle pulse when rdata is updated
- sp  out  ADDR_W  current stack pointer
- stack_fault  out  1  sticky guard error (guard feature only, else tied 0)
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory writeData
- mem_read  out  1  to memory read
- mem_write  out  1  to memory write
- mem_cs  out  1  to memory CS
- mem_read_data  in  DATA_W  from memory readData; combinational, valid the same cycle

Behaviour:
- Reset values: sp=STACK_TOP, state=IDLE, rdata=0, rdata_valid=0, stall=0, stack_fault=0. All mem_* outputs are 0 while rst is high.
- Memory strobes:
  - Combinational from state and op.
  - mem_read and mem_write are never high together; mem_cs is high exactly when either is high.
  - Only address[10:0] is significant at the memory; the upper bits of mem_address are driven 0 for stack accesses.
- FSM states: IDLE, SECOND.
- 16-bit ops, all in IDLE, 1 cycle, stall=0:
  - LOAD: read at ea.
  - STORE: write wdata at ea.
  - PUSH: write at sp, then sp<=sp-1.
  - POP: read at sp+1, then sp<=sp+1.
  - For reads, rdata<=zero-extended mem_read_data on the clock edge, and rdata_valid is high the following cycle.
- CALL:
  - Cycle 1 (IDLE): write pc_in[31:16] at sp, stall=1, go to SECOND.
  - Cycle 2 (SECOND): write pc_in[15:0] at sp-1, sp<=sp-2, stall=0, go to IDLE.
- RET:
  - Cycle 1 (IDLE): read sp+1 into rdata[15:0], stall=1, go to SECOND.
  - Cycle 2 (SECOND): read sp+2 into rdata[31:16], sp<=sp+2, go to IDLE.
  - rdata_valid pulses once, after cycle 2.
- NOP, or op_valid=0: no strobes, no state change.
- Undefined op codes 7: treated as NOP.
- SP arithmetic is modulo 2^11 in bits [10:0]; bits above 10 stay 0. Wrap-around is legal unless the guard feature is enabled.
- Back-to-back ops are fully pipelined; a new op in the cycle after SECOND is accepted.
- Reset during SECOND: aborts immediately. The half-written frame is left in memory and sp returns to STACK_TOP.

Optional Feature:
- Macro: MEM_ACCESS_CTRL_STACK_GUARD_EN.
- Defined:
  - A PUSH/CALL that would move sp below STACK_LIMIT, or a POP/RET that would move sp above STACK_TOP, is suppressed: no strobes, sp unchanged, no stall.
  - stack_fault is set and stays set until reset.
- Undefined: no checks; stack_fault is tied 0.

Decomposition:
- Shared package mem_pkg holds:
  - the op encoding enum (mem_op_t)
  - FSM state enum
  - DATA_W/ADDR_W defaults, STACK_TOP, STACK_LIMIT
- One sub-module, sp_unit: holds the SP register, computes sp+1/sp+2/sp-1/sp-2 and the guard comparisons; the top level contains the FSM and strobe muxing.

Test Plan:
- Reset, then PUSH wdata=0xABCD -> mem write at 2047 with data 0xABCD; sp=2046 next cycle; stall stays 0.
- Following POP -> mem read at 2047; rdata=0x0000ABCD with rdata_valid pulse; sp=2047.
- CALL pc_in=0x12345678 from sp=2047 -> cycle 1 writes 0x1234@2047 with stall=1; cycle 2 writes 0x5678@2046; sp=2045.
- Then RET -> read 2046 then 2047; rdata=0x12345678 with one rdata_valid pulse; sp=2047; stall high for one cycle only.
- STORE ea=0x10 data 0x55AA then LOAD ea=0x10 -> rdata=0x55AA; mem_read and mem_write are never simultaneously high (assertion held throughout).
- rst asserted during SECOND of a CALL -> all strobes low immediately, sp=2047, stall=0. With the guard macro defined, a POP at sp=2047 -> no strobes and stack_fault=1.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory initiator.
// Optional stack guard is enabled with `define MEM_ACCESS_CTRL_STACK_GUARD_EN.
package mem_pkg;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 16;
    localparam int STACK_TOP   = 2047;
    localparam int STACK_LIMIT = 1024;
    localparam int SP_W        = 11;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_CALL  = 3'd5,
        OP_RET   = 3'd6
    } mem_op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SP_HOLD,
        SP_INC1,
        SP_INC2,
        SP_DEC1,
        SP_DEC2
    } sp_step_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Single-word data-memory bus: the controller drives strobes, the memory
// answers combinationally on mem_read_data in the same cycle.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic              mem_cs;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_address, mem_write_data, mem_read, mem_write, mem_cs,
        input  mem_read_data
    );
    modport slave (
        input  mem_address, mem_write_data, mem_read, mem_write, mem_cs,
        output mem_read_data
    );
endinterface

// File: rtl/mem_access_ctrl_sp_unit.sv
// Stack pointer register with neighbour addresses and bound comparisons.
// Only bits [10:0] are live; the upper address bits are always 0.
module sp_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_TOP   = mem_pkg::STACK_TOP,
    parameter int STACK_LIMIT = mem_pkg::STACK_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  sp_step_t          step,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_p1,
    output logic [ADDR_W-1:0] sp_p2,
    output logic [ADDR_W-1:0] sp_m1,
    output logic              push_bad,
    output logic              call_bad,
    output logic              pop_bad,
    output logic              ret_bad
);
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] p1, p2, m1, m2;
    logic [31:0]     sp_wide;

    assign p1 = sp_q + SP_W'(1);
    assign p2 = sp_q + SP_W'(2);
    assign m1 = sp_q - SP_W'(1);
    assign m2 = sp_q - SP_W'(2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_W'(STACK_TOP);
        end else begin
            case (step)
                SP_INC1: sp_q <= p1;
                SP_INC2: sp_q <= p2;
                SP_DEC1: sp_q <= m1;
                SP_DEC2: sp_q <= m2;
                default: sp_q <= sp_q;
            endcase
        end
    end

    assign sp    = ADDR_W'(sp_q);
    assign sp_p1 = ADDR_W'(p1);
    assign sp_p2 = ADDR_W'(p2);
    assign sp_m1 = ADDR_W'(m1);

    // Compared unwrapped, so a step across 0/2047 counts as out of range.
    assign sp_wide  = 32'(sp_q);
    assign push_bad = sp_wide < 32'(STACK_LIMIT + 1);
    assign call_bad = sp_wide < 32'(STACK_LIMIT + 2);
    assign pop_bad  = (sp_wide + 32'd1) > 32'(STACK_TOP);
    assign ret_bad  = (sp_wide + 32'd2) > 32'(STACK_TOP);
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: loads/stores, stack ops and split 32-bit
// call/return frames. Stack guard enabled by MEM_ACCESS_CTRL_STACK_GUARD_EN.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STACK_TOP   = mem_pkg::STACK_TOP,
    parameter int STACK_LIMIT = mem_pkg::STACK_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  ea,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [31:0]        pc_in,
    output logic               stall,
    output logic [31:0]        rdata,
    output logic               rdata_valid,
    output logic [ADDR_W-1:0]  sp,
    output logic               stack_fault,
    mem_access_ctrl_if.master  mem,
    output state_t             dbg_state
);
    state_t            state, next_state;
    logic              sec_ret;
    sp_step_t          step;
    logic [ADDR_W-1:0] sp_p1, sp_p2, sp_m1;
    logic              push_bad, call_bad, pop_bad, ret_bad;
    logic              push_blk, call_blk, pop_blk, ret_blk;
    logic              rd, wr, stall_c, cap_full, cap_lo, cap_hi;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic [15:0]       rd16;
    mem_op_t           op_e;

    assign op_e = mem_op_t'(op);
    assign rd16 = mem.mem_read_data[15:0];

    sp_unit #(
        .ADDR_W(ADDR_W), .STACK_TOP(STACK_TOP), .STACK_LIMIT(STACK_LIMIT)
    ) u_sp (
        .clk(clk), .rst(rst), .step(step),
        .sp(sp), .sp_p1(sp_p1), .sp_p2(sp_p2), .sp_m1(sp_m1),
        .push_bad(push_bad), .call_bad(call_bad),
        .pop_bad(pop_bad), .ret_bad(ret_bad)
    );

    always_comb begin
        rd = 1'b0; wr = 1'b0; addr = '0; wdat = '0; stall_c = 1'b0;
        step = SP_HOLD; next_state = state;
        cap_full = 1'b0; cap_lo = 1'b0; cap_hi = 1'b0;
        if (state == ST_SECOND) begin
            next_state = ST_IDLE;
            if (sec_ret) begin
                rd = 1'b1; addr = sp_p2; step = SP_INC2; cap_hi = 1'b1;
            end else begin
                wr = 1'b1; addr = sp_m1; wdat = DATA_W'(pc_in[15:0]); step = SP_DEC2;
            end
        end else if (op_valid) begin
            case (op_e)
                OP_LOAD: begin rd = 1'b1; addr = ea; cap_full = 1'b1; end
                OP_STORE: begin wr = 1'b1; addr = ea; wdat = wdata; end
                OP_PUSH: if (!push_blk) begin
                    wr = 1'b1; addr = sp; wdat = wdata; step = SP_DEC1;
                end
                OP_POP: if (!pop_blk) begin
                    rd = 1'b1; addr = sp_p1; step = SP_INC1; cap_full = 1'b1;
                end
                OP_CALL: if (!call_blk) begin
                    wr = 1'b1; addr = sp; wdat = DATA_W'(pc_in[31:16]);
                    stall_c = 1'b1; next_state = ST_SECOND;
                end
                OP_RET: if (!ret_blk) begin
                    rd = 1'b1; addr = sp_p1; cap_lo = 1'b1;
                    stall_c = 1'b1; next_state = ST_SECOND;
                end
                default: ;
            endcase
        end
    end

    // Strobes are forced low for the whole reset pulse, including mid-frame.
    assign mem.mem_read       = rd & ~rst;
    assign mem.mem_write      = wr & ~rst;
    assign mem.mem_cs         = (rd | wr) & ~rst;
    assign mem.mem_address    = rst ? '0 : addr;
    assign mem.mem_write_data = rst ? '0 : wdat;
    assign stall              = stall_c & ~rst;
    assign dbg_state          = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sec_ret     <= 1'b0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= next_state;
            rdata_valid <= cap_full | cap_hi;
            if (state == ST_IDLE && next_state == ST_SECOND)
                sec_ret <= (op_e == OP_RET);
            if (cap_full) rdata <= {16'h0, rd16};
            if (cap_lo)   rdata[15:0] <= rd16;
            if (cap_hi)   rdata[31:16] <= rd16;
        end
    end

`ifdef MEM_ACCESS_CTRL_STACK_GUARD_EN
    logic fault_q;
    logic guard_trip;

    assign push_blk = push_bad;
    assign call_blk = call_bad;
    assign pop_blk  = pop_bad;
    assign ret_blk  = ret_bad;
    assign guard_trip = op_valid && (state == ST_IDLE) &&
        ((op_e == OP_PUSH && push_bad) || (op_e == OP_CALL && call_bad) ||
         (op_e == OP_POP && pop_bad)   || (op_e == OP_RET && ret_bad));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             fault_q <= 1'b0;
        else if (guard_trip) fault_q <= 1'b1;
    end
    assign stack_fault = fault_q;
`else
    logic unused_guard;

    assign push_blk = 1'b0;
    assign call_blk = 1'b0;
    assign pop_blk  = 1'b0;
    assign ret_blk  = 1'b0;
    assign unused_guard = ^{push_bad, call_bad, pop_bad, ret_bad};
    assign stack_fault  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 2K x 16 memory model; the
// stack guard expectations follow MEM_ACCESS_CTRL_STACK_GUARD_EN.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    typedef struct {
        logic        ov;
        logic [2:0]  op;
        logic [31:0] ea;
        logic [15:0] wd;
        logic [31:0] pc;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [15:0] e_wd;
        logic        e_stall;
        logic [31:0] e_sp;
        logic        e_rv;
        logic        chk_rd;
        logic [31:0] e_rdata;
        logic        e_fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] ea;
    logic [15:0] wdata;
    logic [31:0] pc_in;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [31:0] sp;
    logic        stack_fault;
    state_t      dbg_state;
    logic [15:0] mem_arr [0:2047];

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(16)) bus ();

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .ea(ea),
        .wdata(wdata), .pc_in(pc_in), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .sp(sp), .stack_fault(stack_fault),
        .mem(bus), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign bus.mem_read_data = (bus.mem_cs && bus.mem_read) ?
                               mem_arr[bus.mem_address[10:0]] : 16'h0;

    always @(posedge clk)
        if (bus.mem_cs && bus.mem_write)
            mem_arr[bus.mem_address[10:0]] <= bus.mem_write_data;

    always @(negedge clk) begin
        total++;
        if ((bus.mem_read && bus.mem_write) ||
            (bus.mem_cs !== (bus.mem_read | bus.mem_write))) begin
            bad++;
            $display("FAIL strobe_excl t=%0t read=%b write=%b cs=%b required exclusive, cs=read|write",
                     $time, bus.mem_read, bus.mem_write, bus.mem_cs);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic ov, input logic [2:0] o, input logic [31:0] a, input logic [15:0] w,
        input logic [31:0] p, input logic erd, input logic ewr, input logic [31:0] eaddr,
        input logic [15:0] ewd, input logic est, input logic [31:0] esp, input logic erv,
        input logic crd, input logic [31:0] erdata, input logic ef);
        vec_t v;
        v.ov = ov; v.op = o; v.ea = a; v.wd = w; v.pc = p;
        v.e_rd = erd; v.e_wr = ewr; v.e_addr = eaddr; v.e_wd = ewd; v.e_stall = est;
        v.e_sp = esp; v.e_rv = erv; v.chk_rd = crd; v.e_rdata = erdata; v.e_fault = ef;
        return v;
    endfunction

    // Drive at posedge+1, check strobes one step later, check registers after the edge.
    task automatic apply(input vec_t v, input string tag);
        op_valid = v.ov; op = v.op; ea = v.ea; wdata = v.wd; pc_in = v.pc;
        #1;
        chk({tag, "_read"},  32'(bus.mem_read),  32'(v.e_rd));
        chk({tag, "_write"}, 32'(bus.mem_write), 32'(v.e_wr));
        chk({tag, "_cs"},    32'(bus.mem_cs),    32'(v.e_rd | v.e_wr));
        chk({tag, "_stall"}, 32'(stall),         32'(v.e_stall));
        if (v.e_rd || v.e_wr) chk({tag, "_addr"}, bus.mem_address, v.e_addr);
        if (v.e_wr) chk({tag, "_wdata"}, 32'(bus.mem_write_data), 32'(v.e_wd));
        @(posedge clk);
        #1;
        chk({tag, "_sp"}, sp, v.e_sp);
        chk({tag, "_rvalid"}, 32'(rdata_valid), 32'(v.e_rv));
        if (v.chk_rd) chk({tag, "_rdata"}, rdata, v.e_rdata);
        chk({tag, "_fault"}, 32'(stack_fault), 32'(v.e_fault));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_arr[i] = 16'h0;

        vecs.push_back(mk(1, 3'd3, 0, 16'hABCD, 0, 0, 1, 2047, 16'hABCD, 0, 2046, 0, 1, 32'h0, 0));
        vecs.push_back(mk(1, 3'd4, 0, 0, 0, 1, 0, 2047, 0, 0, 2047, 1, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2047, 0, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk(1, 3'd5, 0, 0, 32'h12345678, 0, 1, 2047, 16'h1234, 1, 2047, 0, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk(1, 3'd5, 0, 0, 32'h12345678, 0, 1, 2046, 16'h5678, 0, 2045, 0, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk(1, 3'd6, 0, 0, 0, 1, 0, 2046, 0, 1, 2045, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd6, 0, 0, 0, 1, 0, 2047, 0, 0, 2047, 1, 1, 32'h12345678, 0));
        vecs.push_back(mk(1, 3'd2, 32'h10, 16'h55AA, 0, 0, 1, 32'h10, 16'h55AA, 0, 2047, 0, 1, 32'h12345678, 0));
        vecs.push_back(mk(1, 3'd1, 32'h10, 0, 0, 1, 0, 32'h10, 0, 0, 2047, 1, 1, 32'h000055AA, 0));
        vecs.push_back(mk(0, 3'd3, 0, 16'hDEAD, 0, 0, 0, 0, 0, 0, 2047, 0, 1, 32'h000055AA, 0));
        vecs.push_back(mk(1, 3'd7, 0, 16'hDEAD, 0, 0, 0, 0, 0, 0, 2047, 0, 1, 32'h000055AA, 0));
        vecs.push_back(mk(1, 3'd3, 0, 16'h1111, 0, 0, 1, 2047, 16'h1111, 0, 2046, 0, 1, 32'h000055AA, 0));
        vecs.push_back(mk(1, 3'd3, 0, 16'h2222, 0, 0, 1, 2046, 16'h2222, 0, 2045, 0, 1, 32'h000055AA, 0));
        vecs.push_back(mk(1, 3'd4, 0, 0, 0, 1, 0, 2046, 0, 0, 2046, 1, 1, 32'h00002222, 0));
        vecs.push_back(mk(1, 3'd1, 32'hFFFFF7FF, 0, 0, 1, 0, 32'hFFFFF7FF, 0, 0, 2046, 1, 1, 32'h00001111, 0));
        vecs.push_back(mk(1, 3'd4, 0, 0, 0, 1, 0, 2047, 0, 0, 2047, 1, 1, 32'h00001111, 0));
`ifdef MEM_ACCESS_CTRL_STACK_GUARD_EN
        vecs.push_back(mk(1, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 2047, 0, 1, 32'h00001111, 1));
        vecs.push_back(mk(1, 3'd3, 0, 16'h3333, 0, 0, 1, 2047, 16'h3333, 0, 2046, 0, 1, 32'h00001111, 1));
`else
        vecs.push_back(mk(1, 3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(1, 3'd3, 0, 16'h3333, 0, 0, 1, 0, 16'h3333, 0, 2047, 0, 1, 32'h0, 0));
`endif

        // Reset with a PUSH presented: nothing may reach the memory.
        rst = 1'b1; op_valid = 1'b1; op = 3'd3; ea = 0; wdata = 16'hBEEF; pc_in = 0;
        #2;
        chk("rst_read",  32'(bus.mem_read),  0);
        chk("rst_write", 32'(bus.mem_write), 0);
        chk("rst_cs",    32'(bus.mem_cs),    0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sp",    sp, 2047);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", 32'(rdata_valid), 0);
        chk("rst_fault", 32'(stack_fault), 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0; op_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a CALL frame.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("r2_sp", sp, 2047);
        chk("r2_fault", 32'(stack_fault), 0);
        apply(mk(1, 3'd5, 0, 0, 32'hCAFEF00D, 0, 1, 2047, 16'hCAFE, 1, 2047, 0, 0, 0, 0), "call_c1");
        chk("mid_state", 32'(dbg_state), 32'(ST_SECOND));
        chk("mid_write", 32'(bus.mem_write), 1);
        chk("mid_addr",  bus.mem_address, 2046);
        rst = 1'b1;
        #1;
        chk("abort_write", 32'(bus.mem_write), 0);
        chk("abort_read",  32'(bus.mem_read),  0);
        chk("abort_cs",    32'(bus.mem_cs),    0);
        chk("abort_stall", 32'(stall), 0);
        chk("abort_sp",    sp, 2047);
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0; op_valid = 1'b0;
        chk("abort_frame_hi", 32'(mem_arr[2047]), 32'h0000CAFE);
        apply(mk(1, 3'd3, 0, 16'h4444, 0, 0, 1, 2047, 16'h4444, 0, 2046, 0, 1, 32'h0, 0), "post_push");
        op_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
